// File: rtl/aes_req_arbiter.sv
// Two-requester round-robin front end for a single AES128 core: grants one
// operation at a time, launches the core, waits with a timeout and returns the result.
module aes_req_arbiter #(
  parameter int TIMEOUT_CYC = 63
) (
  input  logic         clk,
  input  logic         arst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [127:0] req0_din,
  input  logic [127:0] req0_key,
  input  logic         req0_cipher,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [127:0] req1_din,
  input  logic [127:0] req1_key,
  input  logic         req1_cipher,
  output logic         rsp0_valid,
  input  logic         rsp0_ready,
  output logic [127:0] rsp0_dout,
  output logic         rsp0_err,
  output logic         rsp1_valid,
  input  logic         rsp1_ready,
  output logic [127:0] rsp1_dout,
  output logic         rsp1_err,
  output logic         core_start,
  output logic [127:0] core_din,
  output logic [127:0] core_key,
  output logic         core_cipher,
  input  logic [127:0] core_dout,
  input  logic         core_finish,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

  localparam logic [8:0] TO_LAST = 9'(TIMEOUT_CYC);

  state_t       state_reg, state_next;
  logic         last_served_reg;
  logic         grant_reg, grant_next;
  logic [127:0] din_reg, key_reg, result_reg;
  logic         cipher_reg, err_reg;
  logic [7:0]   cnt_reg;

  logic [1:0]   req_valid, req_ready, rsp_ready, rsp_valid;
  logic         handshake, rsp_hs, timeout_hit;

  assign req_valid = {req1_valid, req0_valid};
  assign rsp_ready = {rsp1_ready, rsp0_ready};

  // Tie goes to whoever was not served last; a lone requester always wins.
  always_comb begin
    grant_next = 1'b0;
    if (req_valid == 2'b11) grant_next = ~last_served_reg;
    else if (req_valid[1])  grant_next = 1'b1;
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    assign req_ready[gi] = !arst && (state_reg == IDLE) && req_valid[gi] && (grant_next == 1'(gi));
    assign rsp_valid[gi] = (state_reg == RESP) && (grant_reg == 1'(gi));
  end

  assign handshake   = |req_ready;
  assign rsp_hs      = |(rsp_valid & rsp_ready);
  // The count is compared post-increment so the response lands TIMEOUT_CYC+1 cycles after start.
  assign timeout_hit = (({1'b0, cnt_reg} + 9'd1) == TO_LAST);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (handshake) state_next = LAUNCH;
      LAUNCH:  state_next = WAIT;
      WAIT:    if (core_finish || timeout_hit) state_next = RESP;
      RESP:    if (rsp_hs) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      state_reg       <= IDLE;
      last_served_reg <= 1'b1;
      grant_reg       <= 1'b0;
      din_reg         <= '0;
      key_reg         <= '0;
      cipher_reg      <= 1'b0;
      cnt_reg         <= '0;
      result_reg      <= '0;
      err_reg         <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (handshake) begin
        grant_reg  <= grant_next;
        din_reg    <= grant_next ? req1_din    : req0_din;
        key_reg    <= grant_next ? req1_key    : req0_key;
        cipher_reg <= grant_next ? req1_cipher : req0_cipher;
      end
      if (state_reg == LAUNCH) begin
        cnt_reg <= '0;
      end else if (state_reg == WAIT) begin
        cnt_reg <= cnt_reg + 8'd1;
        // A finish arriving on the timeout cycle still delivers real data.
        if (core_finish) begin
          result_reg <= core_dout;
          err_reg    <= 1'b0;
        end else if (timeout_hit) begin
          result_reg <= '0;
          err_reg    <= 1'b1;
        end
      end
      if (rsp_hs) last_served_reg <= grant_reg;
    end
  end

  assign req0_ready  = req_ready[0];
  assign req1_ready  = req_ready[1];
  assign rsp0_valid  = rsp_valid[0];
  assign rsp1_valid  = rsp_valid[1];
  assign rsp0_dout   = result_reg;
  assign rsp1_dout   = result_reg;
  assign rsp0_err    = err_reg;
  assign rsp1_err    = err_reg;
  assign core_start  = (state_reg == LAUNCH);
  assign core_din    = din_reg;
  assign core_key    = key_reg;
  assign core_cipher = cipher_reg;
  assign busy        = (state_reg != IDLE);

endmodule

// File: tb/tb_aes_req_arbiter.sv
// Directed bench for aes_req_arbiter: one instance at the default timeout, one at TIMEOUT_CYC=5.
module tb_aes_req_arbiter;

  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] D0  = 128'ha0a0a0a0_00000000_00000000_000000a0;
  localparam logic [127:0] D1  = 128'hb1b1b1b1_11111111_11111111_111111b1;
  localparam logic [127:0] VB  = 128'hcafef00d_00000000_00000000_00000000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic         arst = 1'b1;
  logic         req0_valid = 0, req1_valid = 0, req0_cipher = 0, req1_cipher = 0;
  logic         req0_ready, req1_ready;
  logic [127:0] req0_din = '0, req0_key = '0, req1_din = '0, req1_key = '0;
  logic         rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
  logic         rsp0_ready = 0, rsp1_ready = 0;
  logic [127:0] rsp0_dout, rsp1_dout;
  logic         core_start, core_cipher, busy;
  logic [127:0] core_din, core_key;
  logic [127:0] core_dout = '0;
  logic         core_finish = 1'b0;

  logic         b_arst = 1'b1;
  logic         b_req0_valid = 0, b_req1_valid = 0, b_req0_cipher = 0, b_req1_cipher = 0;
  logic         b_req0_ready, b_req1_ready;
  logic [127:0] b_req0_din = '0, b_req0_key = '0, b_req1_din = '0, b_req1_key = '0;
  logic         b_rsp0_valid, b_rsp1_valid, b_rsp0_err, b_rsp1_err;
  logic         b_rsp0_ready = 0, b_rsp1_ready = 0;
  logic [127:0] b_rsp0_dout, b_rsp1_dout;
  logic         b_core_start, b_core_cipher, b_busy;
  logic [127:0] b_core_din, b_core_key;
  logic [127:0] b_core_dout = 128'hdeadbeef_deadbeef_deadbeef_deadbeef;
  logic         b_core_finish = 1'b0;

  aes_req_arbiter dut (
    .clk(clk), .arst(arst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_din(req0_din), .req0_key(req0_key), .req0_cipher(req0_cipher),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_din(req1_din), .req1_key(req1_key), .req1_cipher(req1_cipher),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_dout(rsp0_dout), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_dout(rsp1_dout), .rsp1_err(rsp1_err),
    .core_start(core_start), .core_din(core_din), .core_key(core_key), .core_cipher(core_cipher),
    .core_dout(core_dout), .core_finish(core_finish), .busy(busy)
  );

  aes_req_arbiter #(.TIMEOUT_CYC(5)) dut_to (
    .clk(clk), .arst(b_arst),
    .req0_valid(b_req0_valid), .req0_ready(b_req0_ready), .req0_din(b_req0_din), .req0_key(b_req0_key), .req0_cipher(b_req0_cipher),
    .req1_valid(b_req1_valid), .req1_ready(b_req1_ready), .req1_din(b_req1_din), .req1_key(b_req1_key), .req1_cipher(b_req1_cipher),
    .rsp0_valid(b_rsp0_valid), .rsp0_ready(b_rsp0_ready), .rsp0_dout(b_rsp0_dout), .rsp0_err(b_rsp0_err),
    .rsp1_valid(b_rsp1_valid), .rsp1_ready(b_rsp1_ready), .rsp1_dout(b_rsp1_dout), .rsp1_err(b_rsp1_err),
    .core_start(b_core_start), .core_din(b_core_din), .core_key(b_core_key), .core_cipher(b_core_cipher),
    .core_dout(b_core_dout), .core_finish(b_core_finish), .busy(b_busy)
  );

  // Core stand-in: called on the core_start cycle, pulses finish lat cycles later,
  // returns on the first cycle after the pulse.
  task automatic core_finish_after(input int lat, input logic [127:0] val);
    repeat (lat) @(negedge clk);
    core_finish = 1'b1;
    core_dout   = val;
    @(negedge clk);
    core_finish = 1'b0;
  endtask

  task automatic test_reset();
    req0_valid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL reset_ready0 got=%b exp=0", req0_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (core_start !== 1'b0) begin errors++; $display("FAIL reset_core_start got=%b exp=0", core_start); end
    checks++; if ({rsp1_valid, rsp0_valid} !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=00", {rsp1_valid, rsp0_valid}); end
    checks++; if (core_din !== '0 || rsp0_dout !== '0 || rsp0_err !== 1'b0) begin errors++; $display("FAIL reset_data got din=%h dout=%h err=%b exp=0", core_din, rsp0_dout, rsp0_err); end
    req0_valid = 1'b0;
    arst = 1'b0; b_arst = 1'b0;
    @(negedge clk);
    $display("reset: ready0=%b busy=%b", req0_ready, busy);
  endtask

  task automatic test_single_encrypt();
    int starts;
    req0_valid = 1'b1; req0_din = PT; req0_key = KEY; req0_cipher = 1'b1;
    #1;
    checks++; if ({req1_ready, req0_ready} !== 2'b01) begin errors++; $display("FAIL enc_ready got=%b exp=01", {req1_ready, req0_ready}); end
    @(negedge clk);
    req0_valid = 1'b0; req0_din = '0;
    checks++; if (core_start !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL enc_start got start=%b busy=%b exp=1,1", core_start, busy); end
    checks++; if (core_din !== PT || core_key !== KEY || core_cipher !== 1'b1) begin errors++; $display("FAIL enc_core_in got din=%h key=%h c=%b", core_din, core_key, core_cipher); end
    starts = 0;
    repeat (11) begin
      @(negedge clk);
      if (core_start) starts++;
    end
    checks++; if (rsp0_valid !== 1'b0) begin errors++; $display("FAIL enc_early_valid got=%b exp=0", rsp0_valid); end
    core_finish = 1'b1; core_dout = CT;
    @(negedge clk);
    core_finish = 1'b0; core_dout = '0;
    checks++; if (starts !== 0) begin errors++; $display("FAIL enc_start_pulses got=%0d extra exp=0", starts); end
    checks++; if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0) begin errors++; $display("FAIL enc_rsp_valid got=%b%b exp=01", rsp1_valid, rsp0_valid); end
    checks++; if (rsp0_dout !== CT || rsp0_err !== 1'b0) begin errors++; $display("FAIL enc_dout got=%h err=%b exp=%h err=0", rsp0_dout, rsp0_err, CT); end
    rsp0_ready = 1'b1;
    @(negedge clk);
    rsp0_ready = 1'b0;
    checks++; if (rsp0_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL enc_release got valid=%b busy=%b exp=0,0", rsp0_valid, busy); end
    checks++; if (core_din !== PT) begin errors++; $display("FAIL enc_core_hold got=%h exp=%h", core_din, PT); end
    $display("single_encrypt: dout=%h err=%b", CT, 1'b0);
  endtask

  task automatic test_tie();
    logic [127:0] v;
    arst = 1'b1;
    @(negedge clk);
    arst = 1'b0;
    req0_valid = 1'b1; req0_din = D0; req0_cipher = 1'b0;
    req1_valid = 1'b1; req1_din = D1; req1_cipher = 1'b1;
    for (int i = 0; i < 4; i++) begin
      v = {96'h0, 32'h1000 + 32'(i)};
      #1;
      checks++; if ({req1_ready, req0_ready} !== ((i % 2) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL tie_grant%0d got=%b exp=%b", i, {req1_ready, req0_ready}, (i % 2) ? 2'b10 : 2'b01); end
      @(negedge clk);
      checks++; if (core_din !== ((i % 2) ? D1 : D0)) begin errors++; $display("FAIL tie_core_din%0d got=%h", i, core_din); end
      core_finish_after(3, v);
      checks++; if ({rsp1_valid, rsp0_valid} !== ((i % 2) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL tie_rsp%0d got=%b", i, {rsp1_valid, rsp0_valid}); end
      checks++; if (rsp0_dout !== v || {req1_ready, req0_ready} !== 2'b00) begin errors++; $display("FAIL tie_resp_data%0d got dout=%h ready=%b exp=%h 00", i, rsp0_dout, {req1_ready, req0_ready}, v); end
      if (i % 2) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
      @(negedge clk);
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      $display("tie: op %0d served req%0d", i, i % 2);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [127:0] v;
    v = 128'h5151_0000_0000_0000_0000_0000_0000_2222;
    req1_valid = 1'b1; req1_din = D1;
    #1;
    checks++; if ({req1_ready, req0_ready} !== 2'b10) begin errors++; $display("FAIL bp_grant got=%b exp=10", {req1_ready, req0_ready}); end
    @(negedge clk);
    req1_valid = 1'b0;
    core_finish_after(4, v);
    core_dout = '0;
    req0_valid = 1'b1; req0_din = D0;
    for (int i = 0; i < 20; i++) begin
      #1;
      checks++; if (rsp1_valid !== 1'b1 || rsp1_dout !== v || rsp1_err !== 1'b0 || req0_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold%0d got valid=%b dout=%h ready0=%b", i, rsp1_valid, rsp1_dout, req0_ready);
      end
      @(negedge clk);
    end
    rsp1_ready = 1'b1;
    @(negedge clk);
    rsp1_ready = 1'b0;
    #1;
    checks++; if (rsp1_valid !== 1'b0 || req0_ready !== 1'b1) begin errors++; $display("FAIL bp_release got valid1=%b ready0=%b exp=0,1", rsp1_valid, req0_ready); end
    req0_valid = 1'b0;
    @(negedge clk);
    $display("backpressure: held 20 cycles dout=%h", v);
  endtask

  task automatic test_reset_mid_wait();
    req0_valid = 1'b1; req0_din = D0; req0_key = KEY; req0_cipher = 1'b1;
    @(negedge clk);
    req0_valid = 1'b0;
    repeat (3) @(negedge clk);
    arst = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (busy !== 1'b0 || core_start !== 1'b0 || {rsp1_valid, rsp0_valid} !== 2'b00) begin errors++; $display("FAIL rst_wait_ctrl got busy=%b start=%b rsp=%b%b", busy, core_start, rsp1_valid, rsp0_valid); end
    checks++; if (core_din !== '0 || core_key !== '0 || core_cipher !== 1'b0 || rsp0_dout !== '0 || rsp0_err !== 1'b0) begin errors++; $display("FAIL rst_wait_data got din=%h key=%h c=%b dout=%h", core_din, core_key, core_cipher, rsp0_dout); end
    arst = 1'b0;
    core_finish = 1'b1; core_dout = VB;
    @(negedge clk);
    core_finish = 1'b0;
    checks++; if (busy !== 1'b0 || rsp0_valid !== 1'b0 || rsp0_dout !== '0) begin errors++; $display("FAIL rst_late_finish got busy=%b valid=%b dout=%h", busy, rsp0_valid, rsp0_dout); end
    req1_valid = 1'b1; req1_din = D1;
    #1;
    checks++; if ({req1_ready, req0_ready} !== 2'b10) begin errors++; $display("FAIL rst_next_grant got=%b exp=10", {req1_ready, req0_ready}); end
    @(negedge clk);
    req1_valid = 1'b0;
    core_finish_after(2, 128'h7777);
    checks++; if (rsp1_valid !== 1'b1 || rsp1_dout !== 128'h7777 || rsp1_err !== 1'b0) begin errors++; $display("FAIL rst_next_rsp got valid=%b dout=%h err=%b", rsp1_valid, rsp1_dout, rsp1_err); end
    rsp1_ready = 1'b1;
    @(negedge clk);
    rsp1_ready = 1'b0;
    $display("reset_mid_wait: abandoned, next op dout=%h", 128'h7777);
  endtask

  task automatic test_timeout();
    b_req0_valid = 1'b1; b_req0_din = PT; b_req0_key = KEY;
    #1;
    checks++; if (b_req0_ready !== 1'b1) begin errors++; $display("FAIL to_ready got=%b exp=1", b_req0_ready); end
    @(negedge clk);
    b_req0_valid = 1'b0;
    checks++; if (b_core_start !== 1'b1) begin errors++; $display("FAIL to_start got=%b exp=1", b_core_start); end
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      checks++; if (b_rsp0_valid !== 1'b0) begin errors++; $display("FAIL to_early%0d got=%b exp=0", k, b_rsp0_valid); end
    end
    @(negedge clk);
    checks++; if (b_rsp0_valid !== 1'b1 || b_rsp0_err !== 1'b1 || b_rsp0_dout !== '0) begin errors++; $display("FAIL to_rsp got valid=%b err=%b dout=%h exp=1,1,0", b_rsp0_valid, b_rsp0_err, b_rsp0_dout); end
    b_core_finish = 1'b1;
    @(negedge clk);
    b_core_finish = 1'b0;
    checks++; if (b_rsp0_valid !== 1'b1 || b_rsp0_err !== 1'b1 || b_rsp0_dout !== '0) begin errors++; $display("FAIL to_late_finish got valid=%b err=%b dout=%h", b_rsp0_valid, b_rsp0_err, b_rsp0_dout); end
    b_rsp0_ready = 1'b1;
    @(negedge clk);
    b_rsp0_ready = 1'b0;
    b_core_finish = 1'b1;
    @(negedge clk);
    b_core_finish = 1'b0;
    checks++; if (b_busy !== 1'b0 || b_rsp0_valid !== 1'b0 || b_rsp0_err !== 1'b1) begin errors++; $display("FAIL to_idle_finish got busy=%b valid=%b err=%b", b_busy, b_rsp0_valid, b_rsp0_err); end
    $display("timeout: err=1 dout=0 at start+6");
  endtask

  task automatic test_finish_at_timeout();
    b_req0_valid = 1'b1;
    @(negedge clk);
    b_req0_valid = 1'b0;
    repeat (5) @(negedge clk);
    b_core_finish = 1'b1; b_core_dout = VB;
    @(negedge clk);
    b_core_finish = 1'b0;
    checks++; if (b_rsp0_valid !== 1'b1 || b_rsp0_err !== 1'b0 || b_rsp0_dout !== VB) begin errors++; $display("FAIL tie_finish got valid=%b err=%b dout=%h exp=1,0,%h", b_rsp0_valid, b_rsp0_err, b_rsp0_dout, VB); end
    b_rsp0_ready = 1'b1;
    @(negedge clk);
    b_rsp0_ready = 1'b0;
    $display("finish_at_timeout: err=0 dout=%h", VB);
  endtask

  initial begin
    test_reset();
    test_single_encrypt();
    test_tie();
    test_backpressure();
    test_reset_mid_wait();
    test_timeout();
    test_finish_at_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_req_arbiter.md
AES_REQ_ARBITER -- requirements
Module: aes_req_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYC, default 63, max cycles waited for core_finish after core_start; legal range 1..255.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 arst  in  1  reset, synchronous, active-high.
REQ-004 reqN_valid  in  1  requester N (N=0,1) has an operation pending.
REQ-005 reqN_ready  out  1  arbiter accepts requester N operation this cycle.
REQ-006 reqN_din  in  128  plaintext/ciphertext block from requester N.
REQ-007 reqN_key  in  128  128-bit key from requester N.
REQ-008 reqN_cipher  in  1  1=encrypt, 0=decrypt, from requester N.
REQ-009 rspN_valid  out  1  result for requester N available.
REQ-010 rspN_ready  in  1  requester N consumes result.
REQ-011 rspN_dout  out  128  result block for requester N.
REQ-012 rspN_err  out  1  result is a timeout error, not valid data.
REQ-013 core_start  out  1  one-cycle start pulse to the AES128 core.
REQ-014 core_din / core_key  out  128 each  block and key driven to the core.
REQ-015 core_cipher  out  1  direction driven to the core.
REQ-016 core_dout  in  128  core result.
REQ-017 core_finish  in  1  core completion pulse.
REQ-018 busy  out  1  high in every state except IDLE.

Function
REQ-019 FSM states IDLE, LAUNCH, WAIT, RESP; exactly one active; no other reachable state.
REQ-020 IDLE: when any reqN_valid is high, grant one requester; reqN_ready = (state==IDLE) && grant==N, combinational; at most one ready high per cycle.
REQ-021 Arbitration: round-robin; one valid -> grant it; both valid -> grant the requester not served last; last_served resets to 1, so req0 wins the first tie.
REQ-022 Handshake cycle T (valid&ready): register din, key, cipher and grant index; next state LAUNCH.
REQ-023 LAUNCH (T+1): core_start=1 for exactly one cycle; clear timeout counter; next state WAIT.
REQ-024 core_din/core_key/core_cipher come from registers; they hold stable from LAUNCH until the next handshake.
REQ-025 WAIT: counter +1 per cycle; core_finish high -> capture core_dout into result register, err=0, next state RESP.
REQ-026 WAIT: counter reaches TIMEOUT_CYC without core_finish -> result=0, err=1, next state RESP.
REQ-027 If core_finish and timeout occur in the same cycle, finish wins (err=0).
REQ-028 core_finish outside WAIT is ignored; no state or result change.
REQ-029 RESP: rspN_valid=1 only for the granted N; dout/err stay stable until rspN_ready.
REQ-030 When rspN_valid&rspN_ready: set last_served=N, return to IDLE; no new request is accepted in that same cycle.
REQ-031 Latency: finish at cycle F gives rspN_valid at F+1; minimum handshake-to-valid is core latency + 2 cycles.
REQ-032 A requester may hold reqN_valid through service; it is not re-accepted until the arbiter returns to IDLE.
REQ-033 Inputs of the non-granted requester have no effect until its handshake.

Reset
REQ-034 While arst is high at a clock edge: state=IDLE; last_served=1; counter=0; result=0; err=0.
REQ-035 Reset output values: core_start=0, reqN_ready=0, rspN_valid=0, rspN_dout=0, rspN_err=0, busy=0, core_din/key/cipher=0.
REQ-036 Reset mid-operation abandons the operation with no response; a late core_finish afterwards is ignored per REQ-028.

Verification
REQ-037 Single encrypt: req0 with key 000102..0f, din 00112233..ff, cipher=1, core model finish after 11 cycles -> one core_start pulse; rsp0_dout=69c4e0d8..c55a; err=0.
REQ-038 Tie: req0 and req1 both valid from reset -> req0 served first, then req1; with both kept valid, grants alternate 0,1,0,1.
REQ-039 Backpressure: hold rsp1_ready=0 for 20 cycles -> rsp1_valid and dout stable; req0 not accepted until rsp1 handshake.
REQ-040 Timeout: core never finishes, TIMEOUT_CYC=5 -> rspN_valid 6 cycles after core_start with err=1 and dout=0; a late finish is ignored.
REQ-041 Reset mid-WAIT: assert arst 3 cycles after core_start -> next cycle all outputs at reset values; the following request completes normally.
REQ-042 Simultaneous finish and timeout in the same cycle -> err=0, dout=core_dout.
